// File: rtl/qu_common_pkg.sv
// Shared Qu core widths and the fetch-queue entry layout.
package qu_common_pkg;

  localparam int QU_PC_WIDTH      = 32;
  localparam int QU_INSTR_WIDTH   = 32;
  localparam int QU_FETCH_WIDTH   = 2;
  localparam int QU_FETCH_Q_DEPTH = 8;

  typedef struct packed {
    logic [QU_PC_WIDTH-1:0]    pc;
    logic [QU_INSTR_WIDTH-1:0] instr;
  } qu_fetch_entry_t;

endpackage

// File: rtl/qu_fetch_queue.sv
// IF->ID instruction queue: up to FETCH_WIDTH {pc,instr} in per cycle, one out per cycle, in order.
// Latency: 1 cycle minimum enqueue-to-dequeue (no fall-through); flush empties it in one cycle.
// Backpressure: enq_ready only when a whole FETCH_WIDTH group fits; deq holds the head while deq_ready is low.
module qu_fetch_queue
  import qu_common_pkg::*;
#(
  parameter int INSTR_WIDTH = QU_INSTR_WIDTH,
  parameter int PC_WIDTH    = QU_PC_WIDTH,
  parameter int DEPTH       = QU_FETCH_Q_DEPTH,
  parameter int FETCH_WIDTH = QU_FETCH_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [FETCH_WIDTH-1:0]          enq_valid,
  output logic                            enq_ready,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0] enq_pc,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] enq_instr,
  output logic                            deq_valid,
  input  logic                            deq_ready,
  output logic [PC_WIDTH-1:0]             deq_pc,
  output logic [INSTR_WIDTH-1:0]          deq_instr,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] FW_EXT    = (CNT_W+1)'(FETCH_WIDTH);

  function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_WIDTH-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  qu_fetch_entry_t        mem [DEPTH];
  qu_fetch_entry_t        lane_dat [FETCH_WIDTH];
  logic [PTR_W-1:0]       lane_idx [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_we;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             enq_fire;
  logic             deq_fire;
  logic [CNT_W-1:0] enq_add;
  qu_fetch_entry_t  head;

  // Readiness looks at the current count only, so it can be registered downstream.
  assign enq_ready = ({1'b0, count} + FW_EXT) <= DEPTH_EXT;
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_ready & (|enq_valid) & ~flush;
  assign deq_fire  = deq_valid & deq_ready & ~flush;
  assign enq_add   = enq_fire ? popcount(enq_valid) : '0;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign lane_idx[i] = wr_ptr + PTR_W'(i);
    assign lane_dat[i] = '{pc:    enq_pc[i*PC_WIDTH +: PC_WIDTH],
                           instr: enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH]};
    assign lane_we[i]  = enq_fire & enq_valid[i];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (lane_we[i]) mem[lane_idx[i]] <= lane_dat[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(enq_add);
      rd_ptr <= rd_ptr + PTR_W'(deq_fire);
      count  <= count + enq_add - CNT_W'(deq_fire);
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out after reset.
  assign head      = mem[rd_ptr];
  assign deq_pc    = deq_valid ? head.pc    : '0;
  assign deq_instr = deq_valid ? head.instr : '0;

endmodule

// File: tb/tb_qu_fetch_queue.sv
// Randomised and directed bench for qu_fetch_queue with a queue-based scoreboard.
module tb_qu_fetch_queue;
  import qu_common_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int PCW   = 32;
  localparam int IW    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [FW-1:0]   enq_valid = '0;
  logic            enq_ready;
  logic [FW*PCW-1:0] enq_pc = '0;
  logic [FW*IW-1:0]  enq_instr = '0;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [PCW-1:0]  deq_pc;
  logic [IW-1:0]   deq_instr;
  logic [3:0]      count;

  always #5 clk = ~clk;

  qu_fetch_queue #(
    .INSTR_WIDTH(IW), .PC_WIDTH(PCW), .DEPTH(DEPTH), .FETCH_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr),
    .count(count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  qu_fetch_entry_t exp_q[$];
  int          m_count   = 0;
  logic [31:0] next_pc   = '0;
  int          deq_total = 0;
  bit          stream_on = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] last_pc   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the queue contents as a plain list, updated once per clock.
  always @(posedge clk) begin
    int n;
    n = 0;
    if (rst || flush) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      if ((DEPTH - m_count >= FW) && (enq_valid != '0)) begin
        for (int i = 0; i < FW; i++) begin
          if (enq_valid[i]) begin
            exp_q.push_back('{pc: enq_pc[i*PCW +: PCW], instr: enq_instr[i*IW +: IW]});
            n++;
          end
        end
        next_pc = next_pc + 32'(4 * n);
      end
      m_count = m_count + n - (((m_count != 0) && deq_ready) ? 1 : 0);
    end
  end

  // Monitor: compares every observable output mid-cycle and retires the head on a dequeue.
  always @(negedge clk) begin
    if (!rst) begin
      if ((enq_valid & (enq_valid + 1'b1)) != '0) begin
        n_chk++;
        $display("FAIL contig_mask: got %b, want contiguous from lane 0", enq_valid);
      end
      chk("count", 32'(count), 32'(m_count));
      chk("deq_valid", 32'(deq_valid), 32'(m_count != 0));
      chk("enq_ready", 32'(enq_ready), 32'(DEPTH - m_count >= FW));
      if (deq_valid && deq_ready && !flush) deq_total++;
      if (m_count != 0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard_empty: got deq_pc 0x%0h, want an expected entry", deq_pc);
        end else begin
          chk("deq_pc", deq_pc, exp_q[0].pc);
          chk("deq_instr", deq_instr, exp_q[0].instr);
          if (deq_ready && !flush) begin
            if (stream_on && have_last) chk("stream_step", deq_pc, last_pc + 32'd4);
            last_pc   = exp_q[0].pc;
            have_last = stream_on;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic [FW-1:0] v, input logic rdy, input logic fl);
    enq_valid = v;
    deq_ready = rdy;
    flush     = fl;
    for (int i = 0; i < FW; i++) begin
      enq_pc[i*PCW +: PCW]  = next_pc + 32'(4 * i);
      enq_instr[i*IW +: IW] = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int issued;
    logic [FW-1:0] mask;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_pc", deq_pc, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 1; k <= 4; k++) begin
      step(2'b11, 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(2 * k));
    end
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_deq_valid", 32'(deq_valid), 32'd1);

    for (int k = 0; k < 8; k++) begin
      chk("order_pc", deq_pc, 32'(4 * k));
      step(2'b00, 1'b1, 1'b0);
    end
    chk("order_drained", 32'(deq_valid), 32'd0);

    repeat (3) step(2'b11, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    chk("seven_count", 32'(count), 32'd7);
    chk("seven_enq_ready", 32'(enq_ready), 32'd0);

    repeat (2) step(2'b00, 1'b1, 1'b0);
    chk("pre_simul_head", deq_pc, 32'd40);
    step(2'b11, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd6);
    chk("simul_head", deq_pc, 32'd44);

    repeat (2) step(2'b00, 1'b1, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd4);
    step(2'b11, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_deq_valid", 32'(deq_valid), 32'd0);
    next_pc = 32'h40;
    step(2'b01, 1'b0, 1'b0);
    chk("post_flush_head", deq_pc, 32'h40);
    step(2'b00, 1'b1, 1'b0);

    next_pc   = 32'h100;
    base      = deq_total;
    issued    = 0;
    mask      = 2'b01;
    stream_on = 1'b1;
    for (int c = 0; c < 2000 && issued < 24; c++) begin
      bit acc;
      acc = (DEPTH - m_count >= FW);
      step(mask, 1'($urandom % 2), 1'b0);
      if (acc) begin
        issued += (mask == 2'b11) ? 2 : 1;
        mask = (mask == 2'b01) ? 2'b11 : 2'b01;
      end
    end
    for (int c = 0; c < 100 && m_count != 0; c++) step(2'b00, 1'b1, 1'b0);
    stream_on = 1'b0;
    chk("stream_none_lost", 32'(deq_total - base), 32'd24);
    chk("stream_last_pc", last_pc, 32'h100 + 32'd92);
    chk("stream_empty", 32'(count), 32'd0);

    step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    enq_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_enq_ready", 32'(enq_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_deq_valid", 32'(deq_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
